// File: rtl/stereo_pattern_generator_pkg.sv
// Shared definitions for the stereo pattern generator: 720p timing defaults,
// pattern codes, FSM states and the counter widths used across the block.
package stereo_pattern_generator_pkg;

    // 720p60 timing defaults (1650 x 750 total)
    localparam int DEF_H_ACTIVE = 1280;
    localparam int DEF_H_FRONT  = 110;
    localparam int DEF_H_SYNC   = 40;
    localparam int DEF_H_BACK   = 220;
    localparam int DEF_V_ACTIVE = 720;
    localparam int DEF_V_FRONT  = 5;
    localparam int DEF_V_SYNC   = 5;
    localparam int DEF_V_BACK   = 20;

    // Counter widths; the right-eye column is one bit wider so col+d never wraps
    localparam int COL_W = 11;
    localparam int ROW_W = 10;
    localparam int XR_W  = 12;
    localparam int PIX_W = 8;

    // Constants used by the pixel patterns
    localparam logic [PIX_W-1:0] FLAT_LEVEL = 8'h80;
    localparam logic [15:0]      HASH_X_MUL = 16'd37;
    localparam logic [15:0]      HASH_Y_MUL = 16'd91;

    typedef enum logic [1:0] {
        PAT_XOR  = 2'd0,
        PAT_RAMP = 2'd1,
        PAT_HASH = 2'd2,
        PAT_FLAT = 2'd3
    } pattern_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } gen_state_t;

endpackage

// File: rtl/stereo_pattern_generator_if.sv
// Video output bundle of the stereo pattern generator: timing strobes plus
// the left/right pixel pair. The generator drives it through the master modport.
interface stereo_pattern_generator_if;
    import stereo_pattern_generator_pkg::*;

    logic             de_out;
    logic             h_sync_out;
    logic             v_sync_out;
    logic             frame_start;
    logic [PIX_W-1:0] pixel_left;
    logic [PIX_W-1:0] pixel_right;

    modport master (
        output de_out,
        output h_sync_out,
        output v_sync_out,
        output frame_start,
        output pixel_left,
        output pixel_right
    );

    modport slave (
        input de_out,
        input h_sync_out,
        input v_sync_out,
        input frame_start,
        input pixel_left,
        input pixel_right
    );

endinterface

// File: rtl/stereo_pattern_pixel.sv
// Combinational pattern function P(x,y,sel). Only the low byte of each
// coordinate reaches the result; the hash products are formed at 16 bits
// and truncated to the pixel width.
module stereo_pattern_pixel
    import stereo_pattern_generator_pkg::*;
(
    input  logic [XR_W-1:0]  i_x,
    input  logic [ROW_W-1:0] i_y,
    input  pattern_t         i_sel,
    output logic [PIX_W-1:0] o_pixel
);

    logic [PIX_W-1:0] w_hash;

    assign w_hash = PIX_W'((16'(i_x) * HASH_X_MUL) ^ (16'(i_y) * HASH_Y_MUL));

    // Select the pattern value for this coordinate
    always_comb begin
        o_pixel = '0;
        case (i_sel)
            PAT_XOR:  o_pixel = i_x[7:0] ^ i_y[7:0];
            PAT_RAMP: o_pixel = i_x[7:0];
            PAT_HASH: o_pixel = w_hash;
            PAT_FLAT: o_pixel = FLAT_LEVEL;
        endcase
    end

endmodule

// File: rtl/stereo_pattern_generator.sv
// Stereo test-pattern generator. A column/row raster runs while the FSM is in
// RUN; every output is registered one clock after the (col,row) state that
// produces it. Enable, disparity and pattern are only taken at the clock that
// enters col=0,row=0, so a frame in flight is never disturbed.
module stereo_pattern_generator
    import stereo_pattern_generator_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FRONT  = DEF_H_FRONT,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BACK   = DEF_H_BACK,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FRONT  = DEF_V_FRONT,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BACK   = DEF_V_BACK
)(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic [7:0]                 disparity,
    input  logic [1:0]                 pattern_sel,
    output logic                       clk_out,
    stereo_pattern_generator_if.master video
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [COL_W-1:0] C_COL_LAST = COL_W'(H_TOTAL - 1);
    localparam logic [COL_W-1:0] C_H_ACT    = COL_W'(H_ACTIVE);
    localparam logic [COL_W-1:0] C_HS_BEG   = COL_W'(H_ACTIVE + H_FRONT);
    localparam logic [COL_W-1:0] C_HS_END   = COL_W'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [ROW_W-1:0] C_ROW_LAST = ROW_W'(V_TOTAL - 1);
    localparam logic [ROW_W-1:0] C_V_ACT    = ROW_W'(V_ACTIVE);
    localparam logic [ROW_W-1:0] C_VS_BEG   = ROW_W'(V_ACTIVE + V_FRONT);
    localparam logic [ROW_W-1:0] C_VS_END   = ROW_W'(V_ACTIVE + V_FRONT + V_SYNC);
    localparam logic [XR_W-1:0]  C_XR_ACT   = XR_W'(H_ACTIVE);

    gen_state_t       r_state;
    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    logic [7:0]       r_disparity;
    pattern_t         r_pattern;

    logic             w_running;
    logic             w_active;
    logic             w_hsync;
    logic             w_vsync;
    logic             w_origin;
    logic             w_lastCol;
    logic             w_lastRow;
    logic [XR_W-1:0]  w_xLeft;
    logic [XR_W-1:0]  w_xRight;
    logic             w_rightInside;
    logic [PIX_W-1:0] w_leftPix;
    logic [PIX_W-1:0] w_rightPix;

    assign clk_out = clk;

    assign w_running     = (r_state == ST_RUN);
    assign w_active      = w_running && (r_col < C_H_ACT) && (r_row < C_V_ACT);
    assign w_hsync       = w_running && (r_col >= C_HS_BEG) && (r_col < C_HS_END);
    assign w_vsync       = w_running && (r_row >= C_VS_BEG) && (r_row < C_VS_END);
    assign w_origin      = (r_col == '0) && (r_row == '0);
    assign w_lastCol     = (r_col == C_COL_LAST);
    assign w_lastRow     = (r_row == C_ROW_LAST);
    assign w_xLeft       = XR_W'(r_col);
    assign w_xRight      = XR_W'(r_col) + XR_W'(r_disparity);
    assign w_rightInside = (w_xRight < C_XR_ACT);

    stereo_pattern_pixel u_pixelLeft (
        .i_x     (w_xLeft),
        .i_y     (r_row),
        .i_sel   (r_pattern),
        .o_pixel (w_leftPix)
    );

    stereo_pattern_pixel u_pixelRight (
        .i_x     (w_xRight),
        .i_y     (r_row),
        .i_sel   (r_pattern),
        .o_pixel (w_rightPix)
    );

    // FSM, raster counters, frame-boundary latches and registered video outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state           <= ST_IDLE;
            r_col             <= '0;
            r_row             <= '0;
            r_disparity       <= '0;
            r_pattern         <= PAT_XOR;
            video.de_out      <= 1'b0;
            video.h_sync_out  <= 1'b0;
            video.v_sync_out  <= 1'b0;
            video.frame_start <= 1'b0;
            video.pixel_left  <= '0;
            video.pixel_right <= '0;
        end else begin
            video.de_out      <= w_active;
            video.h_sync_out  <= w_hsync;
            video.v_sync_out  <= w_vsync;
            video.frame_start <= w_active && w_origin;
            video.pixel_left  <= w_active ? w_leftPix : '0;
            video.pixel_right <= (w_active && w_rightInside) ? w_rightPix : '0;

            case (r_state)
                ST_IDLE: begin
                    r_col <= '0;
                    r_row <= '0;
                    if (enable) begin
                        r_state     <= ST_RUN;
                        r_disparity <= disparity;
                        r_pattern   <= pattern_t'(pattern_sel);
                    end
                end
                ST_RUN: begin
                    if (w_lastCol) begin
                        r_col <= '0;
                        if (w_lastRow) begin
                            r_row <= '0;
                            if (enable) begin
                                r_disparity <= disparity;
                                r_pattern   <= pattern_t'(pattern_sel);
                            end else begin
                                r_state <= ST_IDLE;
                            end
                        end else begin
                            r_row <= r_row + ROW_W'(1);
                        end
                    end else begin
                        r_col <= r_col + COL_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stereo_pattern_generator.sv
// Self-checking bench for stereo_pattern_generator using a reduced raster so
// several whole frames fit in a short run.
module tb_stereo_pattern_generator;

    // Reduced raster: 36 x 17 clocks per frame
    localparam int HA = 24;
    localparam int HF = 3;
    localparam int HS = 4;
    localparam int HB = 5;
    localparam int VA = 10;
    localparam int VF = 2;
    localparam int VS = 2;
    localparam int VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;

    typedef struct {
        int pat;
        int disp;
        int x;
        int y;
        int expL;
        int expR;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic [7:0] disparity = 8'd0;
    logic [1:0] patternSel = 2'd0;
    logic       clkOut;

    stereo_pattern_generator_if vif ();

    stereo_pattern_generator #(
        .H_ACTIVE (HA), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
        .V_ACTIVE (VA), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .disparity   (disparity),
        .pattern_sel (patternSel),
        .clk_out     (clkOut),
        .video       (vif)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nPass = 0;

    // Reference model: running flag, linear position inside the frame, latched settings
    bit mRun = 0;
    int mPos = 0;
    int mD = 0;
    int mPat = 0;

    // Position whose outputs are currently expected on the DUT pins
    bit tbAct = 0;
    int tbCol = 0;
    int tbRow = 0;

    function automatic int patP(int x, int y, int sel);
        case (sel)
            0: return (x ^ y) & 255;
            1: return x & 255;
            2: return ((x * 37) ^ (y * 91)) & 255;
            default: return 128;
        endcase
    endfunction

    function automatic logic [19:0] dutVec();
        return {vif.de_out, vif.h_sync_out, vif.v_sync_out, vif.frame_start,
                vif.pixel_left, vif.pixel_right};
    endfunction

    task automatic checkOutput(string name, int act, int exp);
        nChecks++;
        if (act == exp) nPass++;
        else $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    task automatic modelReset();
        mRun = 0; mPos = 0; mD = 0; mPat = 0;
        tbAct = 0; tbCol = 0; tbRow = 0;
    endtask

    // One clock: advance the model with the inputs seen at the edge, then compare
    task automatic step();
        logic [19:0] e;
        int col, row;
        bit act;
        @(posedge clk);
        col = mPos % HT;
        row = mPos / HT;
        act = mRun && (col < HA) && (row < VA);
        e = '0;
        e[19] = act;
        e[18] = mRun && (col >= HA + HF) && (col < HA + HF + HS);
        e[17] = mRun && (row >= VA + VF) && (row < VA + VF + VS);
        e[16] = act && (mPos == 0);
        e[15:8] = act ? 8'(patP(col, row, mPat)) : 8'd0;
        e[7:0] = (act && (col + mD < HA)) ? 8'(patP(col + mD, row, mPat)) : 8'd0;
        tbAct = act; tbCol = col; tbRow = row;
        if (!mRun) begin
            if (enable) begin
                mRun = 1; mPos = 0; mD = int'(disparity); mPat = int'(patternSel);
            end
        end else begin
            mPos++;
            if (mPos == FRAME) begin
                mPos = 0;
                if (enable) begin
                    mD = int'(disparity); mPat = int'(patternSel);
                end else begin
                    mRun = 0;
                end
            end
        end
        @(negedge clk);
        checkOutput("model_vec", int'(dutVec()), int'(e));
    endtask

    task automatic doReset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        modelReset();
        checkOutput("reset_outputs", int'(dutVec()), 0);
        rst = 1'b0;
    endtask

    // Step until the outputs of active pixel (x,y) are on the pins
    task automatic seek(int x, int y);
        bit found = 0;
        for (int n = 0; n < 3 * FRAME && !found; n++) begin
            step();
            if (tbAct && tbCol == x && tbRow == y) found = 1;
        end
        if (!found) checkOutput("seek_timeout", 0, 1);
    endtask

    task automatic applyStimulus(vec_t v);
        patternSel = 2'(v.pat);
        disparity = 8'(v.disp);
        enable = 1'b1;
        doReset();
        seek(v.x, v.y);
        checkOutput($sformatf("tbl_left_p%0d_d%0d_%0d_%0d", v.pat, v.disp, v.x, v.y), int'(vif.pixel_left), v.expL);
        checkOutput($sformatf("tbl_right_p%0d_d%0d_%0d_%0d", v.pat, v.disp, v.x, v.y), int'(vif.pixel_right), v.expR);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs[10];
        int deCnt, hsCnt, vsCnt, deLines, hsLines, lrDiff;
        int deFall, hsRise, hsFall, fsCnt;
        bit prevDe, prevHs;

        vecs[0] = '{1, 5, 10, 0, 10, 15};
        vecs[1] = '{1, 5, 19, 0, 19, 0};
        vecs[2] = '{1, 5, 18, 3, 18, 23};
        vecs[3] = '{0, 0, 5, 3, 6, 6};
        vecs[4] = '{0, 2, 7, 6, 1, 15};
        vecs[5] = '{2, 0, 3, 2, 217, 217};
        vecs[6] = '{2, 4, 1, 1, 126, 226};
        vecs[7] = '{3, 1, 0, 0, 128, 128};
        vecs[8] = '{3, 1, 23, 4, 128, 0};
        vecs[9] = '{0, 255, 0, 0, 0, 0};

        $display("[TB] start");
        doReset();
        checkOutput("clk_out_low", int'(clkOut), int'(clk));
        #5;
        checkOutput("clk_out_high", int'(clkOut), int'(clk));
        @(negedge clk);

        // Idle with enable low: nothing moves
        for (int i = 0; i < 20; i++) step();

        // Table of single-pixel vectors
        foreach (vecs[i]) applyStimulus(vecs[i]);

        // Full frame timing, pattern 0, d=0
        $display("[TB] frame timing");
        patternSel = 2'd0; disparity = 8'd0; enable = 1'b1;
        doReset();
        step();
        checkOutput("fs_first_run_clock", int'(vif.frame_start), 0);
        step();
        checkOutput("fs_after_first_run", int'(vif.frame_start), 1);
        deCnt = 0; hsCnt = 0; vsCnt = 0; deLines = 0; hsLines = 0; lrDiff = 0;
        deFall = -1; hsRise = -1; hsFall = -1; prevDe = 0; prevHs = 0;
        for (int c = 0; c < FRAME; c++) begin
            if (vif.de_out) deCnt++;
            if (vif.h_sync_out) hsCnt++;
            if (vif.v_sync_out) vsCnt++;
            if (vif.de_out && !prevDe) deLines++;
            if (vif.h_sync_out && !prevHs) hsLines++;
            if (prevDe && !vif.de_out && deFall < 0) deFall = c;
            if (!prevHs && vif.h_sync_out && hsRise < 0) hsRise = c;
            if (prevHs && !vif.h_sync_out && hsFall < 0) hsFall = c;
            if (vif.pixel_left != vif.pixel_right) lrDiff++;
            prevDe = vif.de_out;
            prevHs = vif.h_sync_out;
            step();
        end
        checkOutput("frame_period_fs", int'(vif.frame_start), 1);
        checkOutput("de_clocks", deCnt, HA * VA);
        checkOutput("de_lines", deLines, VA);
        checkOutput("hs_clocks", hsCnt, HS * VT);
        checkOutput("hs_lines", hsLines, VT);
        checkOutput("vs_clocks", vsCnt, VS * HT);
        checkOutput("hs_delay_after_de", hsRise - deFall, HF);
        checkOutput("hs_width", hsFall - hsRise, HS);
        checkOutput("left_eq_right_d0", lrDiff, 0);

        // Right edge clamp and disparity change mid-frame
        $display("[TB] disparity change");
        patternSel = 2'd1; disparity = 8'd5; enable = 1'b1;
        doReset();
        seek(10, 1);
        checkOutput("d5_right_col10", int'(vif.pixel_right), 15);
        seek(19, 1);
        for (int x = 19; x < HA; x++) begin
            checkOutput($sformatf("d5_right_clamp_col%0d", x), int'(vif.pixel_right), 0);
            if (x < HA - 1) step();
        end
        disparity = 8'd9;
        seek(10, 6);
        checkOutput("d9_pending_right", int'(vif.pixel_right), 15);
        seek(10, 0);
        checkOutput("d9_applied_right", int'(vif.pixel_right), 19);
        checkOutput("d9_applied_left", int'(vif.pixel_left), 10);

        // Enable dropped mid-frame
        $display("[TB] enable drop");
        patternSel = 2'd0; disparity = 8'd3; enable = 1'b1;
        doReset();
        seek(5, 3);
        enable = 1'b0;
        deCnt = 0; fsCnt = 0;
        for (int c = 0; c < 2 * FRAME; c++) begin
            step();
            if (vif.de_out) deCnt++;
            if (vif.frame_start) fsCnt++;
        end
        checkOutput("frame_completes", deCnt, HA * VA - (3 * HA + 6));
        checkOutput("no_new_frame", fsCnt, 0);
        checkOutput("idle_outputs", int'(dutVec()), 0);
        enable = 1'b1;
        step();
        checkOutput("reenable_fs_early", int'(vif.frame_start), 0);
        step();
        checkOutput("reenable_fs", int'(vif.frame_start), 1);

        // Asynchronous reset mid-frame
        $display("[TB] async reset");
        patternSel = 2'd2; disparity = 8'd3; enable = 1'b1;
        doReset();
        seek(3, 5);
        checkOutput("pre_reset_de", int'(vif.de_out), 1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_reset_outputs", int'(dutVec()), 0);
        @(negedge clk);
        @(negedge clk);
        modelReset();
        rst = 1'b0;
        step();
        checkOutput("post_reset_fs_early", int'(vif.frame_start), 0);
        step();
        checkOutput("post_reset_fs", int'(vif.frame_start), 1);
        checkOutput("post_reset_left", int'(vif.pixel_left), 0);

        // Randomized run against the model
        $display("[TB] random");
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                disparity = ($urandom_range(0, 9) == 0) ? 8'd255 : 8'($urandom_range(0, 30));
                patternSel = 2'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 399) == 0) enable = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
